// File: rtl/datapath_pipe.sv
// Three-stage (RD / EX / WB) pipelined datapath: register file, immediate generator and ALU.
// Dependencies are forwarded from WB into both RD and EX, so any instruction stream runs without bubbles.
module datapath_pipe #(
  parameter int WAD    = 5,
  parameter int WD     = 32,
  parameter int A0_IDX = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           stall,
  input  logic [WAD-1:0] AdIn,
  input  logic [WAD-1:0] AdOut1,
  input  logic [WAD-1:0] AdOut2,
  input  logic [WD-1:0]  instr,
  input  logic           ALUsrc,
  input  logic [2:0]     ALUctrl,
  input  logic           RegWrite,
  input  logic [1:0]     IMMsrc,
  output logic           wb_valid,
  output logic [WAD-1:0] wb_rd,
  output logic [WD-1:0]  wb_data,
  output logic           EQ,
  output logic [WD-1:0]  IMM,
  output logic [WD-1:0]  A0
);

  localparam int NREG = 2**WAD;
  localparam logic [WAD-1:0] A0_AD = WAD'(A0_IDX);

  logic [WD-1:0]  r_regs [NREG];

  logic           r_ex_valid;
  logic [WAD-1:0] r_ex_rd;
  logic [WAD-1:0] r_ex_rs1;
  logic [WAD-1:0] r_ex_rs2;
  logic [WD-1:0]  r_ex_d1;
  logic [WD-1:0]  r_ex_d2;
  logic [WD-1:0]  r_ex_imm;
  logic           r_ex_alusrc;
  logic [2:0]     r_ex_aluctrl;
  logic           r_ex_rw;

  logic           r_wb_valid;
  logic [WAD-1:0] r_wb_rd;
  logic [WD-1:0]  r_wb_data;
  logic           r_wb_eq;
  logic [WD-1:0]  r_wb_imm;
  logic           r_wb_rw;

  logic signed [31:0] w_imm32;
  logic [WD-1:0]  w_imm;
  logic           w_wb_fwd;
  logic [WD-1:0]  w_rd1;
  logic [WD-1:0]  w_rd2;
  logic [WD-1:0]  w_n1;
  logic [WD-1:0]  w_src2;
  logic [WD-1:0]  w_n2;
  logic [WD-1:0]  w_alu;
  logic           w_unused;

  // Handshake: an instruction is taken on a rising edge where in_valid && in_ready;
  // in_ready is simply !stall, and a stalled edge changes no state at all.
  assign in_ready = !stall;
  assign w_unused = ^instr;

  always_comb begin
    w_imm32 = '0;
    case (IMMsrc)
      2'b00: w_imm32 = {{20{instr[31]}}, instr[31:20]};
      2'b01: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      2'b10: w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      2'b11: w_imm32 = {instr[31:12], 12'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm = WD'(w_imm32);

  // A WB instruction forwards only if it will actually write a non-zero register.
  assign w_wb_fwd = r_wb_valid && r_wb_rw && (r_wb_rd != '0);

  assign w_rd1 = (w_wb_fwd && (r_wb_rd == AdOut1)) ? r_wb_data :
                 (AdOut1 == '0) ? '0 : r_regs[AdOut1];
  assign w_rd2 = (w_wb_fwd && (r_wb_rd == AdOut2)) ? r_wb_data :
                 (AdOut2 == '0) ? '0 : r_regs[AdOut2];

  assign w_n1   = (w_wb_fwd && (r_wb_rd == r_ex_rs1)) ? r_wb_data : r_ex_d1;
  assign w_src2 = (w_wb_fwd && (r_wb_rd == r_ex_rs2)) ? r_wb_data : r_ex_d2;
  assign w_n2   = r_ex_alusrc ? r_ex_imm : w_src2;

  always_comb begin
    w_alu = '0;
    case (r_ex_aluctrl)
      3'b000: w_alu = w_n1 + w_n2;
      3'b001: w_alu = w_n1 - w_n2;
      3'b010: w_alu = w_n1 & w_n2;
      3'b011: w_alu = w_n1 | w_n2;
      3'b100: w_alu = w_n1 ^ w_n2;
      3'b101: w_alu = WD'($signed(w_n1) < $signed(w_n2));
      3'b110: w_alu = w_n1 << w_n2[4:0];
      3'b111: w_alu = w_n1 >> w_n2[4:0];
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_rd      <= '0;
      r_ex_rs1     <= '0;
      r_ex_rs2     <= '0;
      r_ex_d1      <= '0;
      r_ex_d2      <= '0;
      r_ex_imm     <= '0;
      r_ex_alusrc  <= 1'b0;
      r_ex_aluctrl <= '0;
      r_ex_rw      <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_wb_eq      <= 1'b0;
      r_wb_imm     <= '0;
      r_wb_rw      <= 1'b0;
    end else if (!stall) begin
      r_ex_valid   <= in_valid;
      r_ex_rd      <= AdIn;
      r_ex_rs1     <= AdOut1;
      r_ex_rs2     <= AdOut2;
      r_ex_d1      <= w_rd1;
      r_ex_d2      <= w_rd2;
      r_ex_imm     <= w_imm;
      r_ex_alusrc  <= ALUsrc;
      r_ex_aluctrl <= ALUctrl;
      r_ex_rw      <= RegWrite;
      r_wb_valid   <= r_ex_valid;
      r_wb_rd      <= r_ex_rd;
      r_wb_data    <= w_alu;
      r_wb_eq      <= (w_n1 == w_n2);
      r_wb_imm     <= r_ex_imm;
      r_wb_rw      <= r_ex_rw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (!stall && w_wb_fwd) begin
      r_regs[r_wb_rd] <= r_wb_data;
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign EQ       = r_wb_eq;
  assign IMM      = r_wb_imm;
  assign A0       = r_regs[A0_AD];

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: an in-order architectural model predicts each WB result,
// which a negedge monitor pops and compares; directed hazard, stall and reset cases plus a random stream.
module tb_datapath_pipe;

  localparam int WAD = 5;
  localparam int WD  = 32;
  localparam int EW  = 1 + WD + WAD + WD;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           stall = 1'b0;
  logic [WAD-1:0] AdIn = '0;
  logic [WAD-1:0] AdOut1 = '0;
  logic [WAD-1:0] AdOut2 = '0;
  logic [WD-1:0]  instr = '0;
  logic           ALUsrc = 1'b0;
  logic [2:0]     ALUctrl = '0;
  logic           RegWrite = 1'b0;
  logic [1:0]     IMMsrc = '0;
  logic           wb_valid;
  logic [WAD-1:0] wb_rd;
  logic [WD-1:0]  wb_data;
  logic           EQ;
  logic [WD-1:0]  IMM;
  logic [WD-1:0]  A0;

  logic [WD-1:0]  m_regs [32];
  logic [EW-1:0]  exp_q[$];
  int             n_checks = 0;
  int             n_errors = 0;
  logic           adv = 1'b0;

  datapath_pipe #(.WAD(WAD), .WD(WD), .A0_IDX(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
    .AdIn(AdIn), .AdOut1(AdOut1), .AdOut2(AdOut2), .instr(instr), .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl), .RegWrite(RegWrite), .IMMsrc(IMMsrc), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .EQ(EQ), .IMM(IMM), .A0(A0)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WD-1:0] f_imm(input logic [31:0] ins, input logic [1:0] sel);
    case (sel)
      2'b00:   return {{20{ins[31]}}, ins[31:20]};
      2'b01:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      2'b10:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      default: return {ins[31:12], 12'h000};
    endcase
  endfunction

  function automatic logic [WD-1:0] f_alu(input logic [2:0] op, input logic [WD-1:0] a, input logic [WD-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] ins, input logic alusrc, input logic [2:0] op,
                       input logic rw, input logic [1:0] isel);
    logic [WD-1:0] imm, n1, n2, res;
    in_valid = 1'b1; AdIn = rd; AdOut1 = rs1; AdOut2 = rs2; instr = ins;
    ALUsrc = alusrc; ALUctrl = op; RegWrite = rw; IMMsrc = isel;
    imm = f_imm(ins, isel);
    n1  = m_regs[rs1];
    n2  = alusrc ? imm : m_regs[rs2];
    res = f_alu(op, n1, n2);
    exp_q.push_back({(n1 == n2), imm, rd, res});
    if (rw && rd != 0) m_regs[rd] = res;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    issue(rd, rs1, 5'd0, {imm, 20'h00000}, 1'b1, 3'd0, 1'b1, 2'b00);
  endtask

  task automatic rop(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    issue(rd, rs1, rs2, 32'h0, 1'b0, op, 1'b1, 2'b00);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) adv <= rst_n && !stall;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (adv && wb_valid) begin
      check("wb_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wb_data", wb_data, e[WD-1:0]);
        check("wb_rd",   wb_rd,   e[WD+WAD-1:WD]);
        check("IMM",     IMM,     e[2*WD+WAD-1:WD+WAD]);
        check("EQ",      EQ,      e[EW-1]);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [WD-1:0]  s_data, s_a0;
    logic           s_valid;
    logic [WAD-1:0] s_rd;
    model_clear();
    #12;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data",  wb_data, 0);
    check("rst_wb_rd",    wb_rd, 0);
    check("rst_EQ",       EQ, 0);
    check("rst_IMM",      IMM, 0);
    check("rst_A0",       A0, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // ADDI x10,x0,5: WB after E1, A0 after E2
    issue(5'd10, 5'd0, 5'd0, 32'h00500513, 1'b1, 3'd0, 1'b1, 2'b00);
    check("addi_a0_early", A0, 0);
    @(posedge clk); #1;
    check("addi_wb_valid", wb_valid, 1);
    check("addi_a0_before_write", A0, 0);
    @(posedge clk); #1;
    check("addi_a0", A0, 5);
    idle(1);

    // back-to-back dependents, distance 1 and 2
    addi(5'd1, 5'd0, 12'd7);
    rop(3'd0, 5'd2, 5'd1, 5'd1);
    rop(3'd0, 5'd3, 5'd1, 5'd2);
    @(negedge clk);
    check("b2b_valid_2", wb_valid, 1);
    check("b2b_data_2", wb_data, 14);
    @(negedge clk);
    check("b2b_valid_3", wb_valid, 1);
    check("b2b_data_3", wb_data, 21);
    idle(2);

    // ALU corner cases
    rop(3'd1, 5'd5, 5'd1, 5'd1);
    addi(5'd6, 5'd0, 12'hFFF);
    addi(5'd7, 5'd0, 12'd1);
    rop(3'd5, 5'd8, 5'd6, 5'd7);
    rop(3'd5, 5'd8, 5'd7, 5'd6);
    issue(5'd9, 5'd0, 5'd0, 32'h80000000, 1'b1, 3'd0, 1'b1, 2'b11);
    addi(5'd11, 5'd0, 12'd31);
    rop(3'd7, 5'd12, 5'd9, 5'd11);
    rop(3'd6, 5'd12, 5'd7, 5'd11);
    rop(3'd2, 5'd4, 5'd6, 5'd3);
    issue(5'd4, 5'd3, 5'd0, 32'hFE000F80, 1'b1, 3'd4, 1'b1, 2'b01);
    issue(5'd4, 5'd3, 5'd0, 32'h800007FF, 1'b1, 3'd3, 1'b1, 2'b10);

    // writes to x0 are discarded
    addi(5'd0, 5'd0, 12'd9);
    rop(3'd0, 5'd4, 5'd0, 5'd0);
    idle(4);

    // stall with two instructions in flight
    addi(5'd10, 5'd0, 12'h077);
    rop(3'd0, 5'd13, 5'd10, 5'd10);
    stall = 1'b1;
    in_valid = 1'b1; AdIn = 5'd10; AdOut1 = 5'd3; instr = $urandom; RegWrite = 1'b1;
    #1;
    check("stall_in_ready", in_ready, 0);
    s_data = wb_data; s_valid = wb_valid; s_rd = wb_rd; s_a0 = A0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      instr = $urandom; AdIn = 5'($urandom_range(1, 12));
      check("stall_wb_data", wb_data, s_data);
      check("stall_wb_valid", wb_valid, s_valid);
      check("stall_wb_rd", wb_rd, s_rd);
      check("stall_A0", A0, s_a0);
      check("stall_in_ready_hold", in_ready, 0);
    end
    stall = 1'b0;
    in_valid = 1'b0;
    idle(3);
    check("post_stall_A0", A0, 32'h77);
    rop(3'd0, 5'd14, 5'd13, 5'd0);
    idle(3);

    // random stream with gaps and stalls
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 7) == 0) begin
        stall = 1'b1;
        idle($urandom_range(1, 3));
        stall = 1'b0;
      end
      issue(5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)),
            $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)));
    end
    idle(4);
    check("rand_A0", A0, m_regs[10]);
    check("drain_q_empty", exp_q.size(), 0);

    // reset while ADDI x10 sits in EX
    addi(5'd10, 5'd0, 12'h055);
    rst_n = 1'b0;
    #1;
    check("midrst_A0", A0, 0);
    check("midrst_wb_valid", wb_valid, 0);
    model_clear();
    idle(2);
    rst_n = 1'b1;
    idle(4);
    check("after_rst_A0", A0, 0);
    check("after_rst_wb_valid", wb_valid, 0);
    check("after_rst_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
